// File: rtl/disp_pkg.sv
// Shared constants and helpers for the 4-digit multiplexed display scheduler.
package disp_pkg;

  localparam int unsigned NIB_W   = 4;
  localparam int unsigned FRAME_W = 16;

  // Active-low digit enables
  localparam logic [3:0] ANODE_OFF = 4'b1111;
  localparam logic [3:0] ANODE_D0  = 4'b1110;
  localparam logic [3:0] ANODE_D1  = 4'b1101;
  localparam logic [3:0] ANODE_D2  = 4'b1011;
  localparam logic [3:0] ANODE_D3  = 4'b0111;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SEL_PC  = 2'd0,
    SEL_INS = 2'd1,
    SEL_ALU = 2'd2,
    SEL_DB  = 2'd3
  } sel_e;

  // Anode pattern for a digit index (idx0 is the leftmost digit)
  function automatic logic [3:0] anode_for(input logic [1:0] idx);
    logic [3:0] a;
    case (idx)
      2'd0:    a = ANODE_D0;
      2'd1:    a = ANODE_D1;
      2'd2:    a = ANODE_D2;
      default: a = ANODE_D3;
    endcase
    return a;
  endfunction

  // Nibble of the latched frame shown at a digit index (idx0 = MS nibble)
  function automatic logic [NIB_W-1:0] nibble_at(input logic [FRAME_W-1:0] f,
                                                 input logic [1:0]         idx);
    logic [NIB_W-1:0] n;
    case (idx)
      2'd0:    n = f[15:12];
      2'd1:    n = f[11:8];
      2'd2:    n = f[7:4];
      default: n = f[3:0];
    endcase
    return n;
  endfunction

  // True when every nibble from the MS digit down to idx is zero; the last digit never qualifies
  function automatic logic leading_zero(input logic [FRAME_W-1:0] f,
                                        input logic [1:0]         idx);
    logic z;
    case (idx)
      2'd0:    z = (f[15:12] == 4'h0);
      2'd1:    z = (f[15:8]  == 8'h00);
      2'd2:    z = (f[15:4]  == 12'h000);
      default: z = 1'b0;
    endcase
    return z;
  endfunction

endpackage

// File: rtl/disp_prescaler.sv
// Phase counter: counts 0..len_m1 while enabled and wraps to zero after the last cycle.
module disp_prescaler #(
  parameter int unsigned CNT_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] len_m1,
  output logic             last_c,
  output logic [CNT_W-1:0] cnt_nxt_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign last_c    = (cnt_q == len_m1);
  assign cnt_nxt_c = cnt_d;

  // Next count: hold when disabled, clear on the last cycle of a phase
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Scan scheduler for the 4-digit 7-segment display: frame latch, BLANK/SHOW sequencing,
// leading-zero blanking and frame-done strobe. All outputs are registered.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned DIV       = 50000,
  parameter int unsigned BLANK_CYC = 500,
  parameter int unsigned CNT_W     = 17
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        En,
  input  logic [1:0]  Sel,
  input  logic [15:0] Src0,
  input  logic [15:0] Src1,
  input  logic [15:0] Src2,
  input  logic [15:0] Src3,
  input  logic        LZB,
  output logic [3:0]  Digit,
  output logic [3:0]  Anode,
  output logic        Blank,
  output logic        FrameDone
);

  localparam logic [CNT_W-1:0] DIV_M1   = CNT_W'(DIV - 1);
  // A zero-length BLANK only occurs as the reset state; it then lasts a single cycle
  localparam logic [CNT_W-1:0] BLANK_M1 = (BLANK_CYC == 0) ? '0 : CNT_W'(BLANK_CYC - 1);
  localparam logic             NO_BLANK = (BLANK_CYC == 0);

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   frame_q, frame_d;
  logic          lzb_q, lzb_d;
  logic          pend_q, pend_d;
  logic [3:0]    anode_q, anode_d;
  logic [3:0]    digit_q, digit_d;
  logic          blank_q, blank_d;
  logic          fd_q, fd_d;

  logic [15:0]      src_c;
  logic [CNT_W-1:0] len_m1_c;
  logic [CNT_W-1:0] cnt_nxt_c;
  logic             last_c;
  logic             sup_c;

  assign len_m1_c = (state_q == ST_BLANK) ? BLANK_M1 : DIV_M1;

  disp_prescaler #(
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk       (CLK),
    .rst_n     (Reset),
    .en        (En),
    .len_m1    (len_m1_c),
    .last_c    (last_c),
    .cnt_nxt_c (cnt_nxt_c)
  );

  // Source mux feeding the frame latch
  always_comb begin
    src_c = Src0;
    case (sel_e'(Sel))
      SEL_PC:  src_c = Src0;
      SEL_INS: src_c = Src1;
      SEL_ALU: src_c = Src2;
      SEL_DB:  src_c = Src3;
      default: src_c = Src0;
    endcase
  end

  // Next state, frame latch and registered output values for the state being entered
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    lzb_d   = lzb_q;
    pend_d  = pend_q;
    anode_d = ANODE_OFF;
    digit_d = digit_q;
    blank_d = 1'b1;
    fd_d    = 1'b0;
    sup_c   = 1'b0;

    if (En) begin
      if (last_c) begin
        if (state_q == ST_BLANK) begin
          state_d = ST_SHOW;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = NO_BLANK ? ST_SHOW : ST_BLANK;
        end
      end

      // Latch on entry to a new frame; after reset, latch during the first idx0 cycle
      if (pend_q || (last_c && (state_q == ST_SHOW) && (idx_q == 2'd3))) begin
        frame_d = src_c;
        lzb_d   = LZB;
        pend_d  = 1'b0;
      end

      digit_d = nibble_at(frame_d, idx_d);
      sup_c   = lzb_d && leading_zero(frame_d, idx_d);
      if ((state_d == ST_SHOW) && !sup_c) begin
        anode_d = anode_for(idx_d);
        blank_d = 1'b0;
      end
      fd_d = (state_d == ST_SHOW) && (idx_d == 2'd3) && (cnt_nxt_c == DIV_M1);
    end
  end

  // State and output registers
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_BLANK;
      idx_q   <= 2'd0;
      frame_q <= 16'h0000;
      lzb_q   <= 1'b0;
      pend_q  <= 1'b1;
      anode_q <= ANODE_OFF;
      digit_q <= 4'h0;
      blank_q <= 1'b1;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      lzb_q   <= lzb_d;
      pend_q  <= pend_d;
      anode_q <= anode_d;
      digit_q <= digit_d;
      blank_q <= blank_d;
      fd_q    <= fd_d;
    end
  end

  assign Digit     = digit_q;
  assign Anode     = anode_q;
  assign Blank     = blank_q;
  assign FrameDone = fd_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl: per-frame expected cycles are queued when the
// frame's source is set up and popped/compared every cycle.
module tb_disp_scan_ctrl;

  typedef struct packed {
    logic [3:0] anode;
    logic [3:0] digit;
    logic       blank;
    logic       fd;
    logic       chk_dig;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  sel;
  logic [15:0] src0, src1, src2, src3;
  logic        lzb;

  logic [3:0]  a_digit, a_anode;
  logic        a_blank, a_fd;
  logic [3:0]  b_digit, b_anode;
  logic        b_blank, b_fd;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  disp_scan_ctrl #(.DIV(4), .BLANK_CYC(1), .CNT_W(17)) u_dut_a (
    .CLK(clk), .Reset(rst_n), .En(en), .Sel(sel),
    .Src0(src0), .Src1(src1), .Src2(src2), .Src3(src3), .LZB(lzb),
    .Digit(a_digit), .Anode(a_anode), .Blank(a_blank), .FrameDone(a_fd)
  );

  disp_scan_ctrl #(.DIV(2), .BLANK_CYC(0), .CNT_W(17)) u_dut_b (
    .CLK(clk), .Reset(rst_n), .En(en), .Sel(sel),
    .Src0(src0), .Src1(src1), .Src2(src2), .Src3(src3), .LZB(lzb),
    .Digit(b_digit), .Anode(b_anode), .Blank(b_blank), .FrameDone(b_fd)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_off(input int n);
    exp_t e;
    for (int j = 0; j < n; j++) begin
      e = '{anode: 4'b1111, digit: 4'h0, blank: 1'b1, fd: 1'b0, chk_dig: 1'b0};
      sb_q.push_back(e);
    end
  endtask

  // Expected cycles of one frame (DIV=4, BLANK_CYC=1); en_len off cycles follow entry en_at
  task automatic push_frame(input logic [15:0] v, input logic lz, input int en_at, input int en_len);
    exp_t e;
    int   i;
    logic [3:0] nib;
    logic sup;
    i = 0;
    for (int k = 0; k < 4; k++) begin
      nib = 4'(v >> (12 - 4 * k));
      sup = lz && (k < 3) && ((v >> (12 - 4 * k)) == 16'h0000);
      push_off(1);
      if (i == en_at) push_off(en_len);
      i++;
      for (int c = 0; c < 4; c++) begin
        e.anode   = sup ? 4'b1111 : 4'(~(4'b0001 << k));
        e.digit   = nib;
        e.blank   = sup;
        e.fd      = (k == 3) && (c == 3);
        e.chk_dig = 1'b1;
        sb_q.push_back(e);
        if (i == en_at) push_off(en_len);
        i++;
      end
    end
  endtask

  task automatic step(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_underrun"}, 16'(sb_q.size()), 16'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_anode"}, 16'(a_anode), 16'(e.anode));
      chk({tag, "_blank"}, 16'(a_blank), 16'(e.blank));
      chk({tag, "_fd"},    16'(a_fd),    16'(e.fd));
      if (e.chk_dig) chk({tag, "_digit"}, 16'(a_digit), 16'(e.digit));
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input string tag, input int n);
    for (int j = 0; j < n; j++) step(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=%0t exp=<200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; en = 1'b1; sel = 2'd0; lzb = 1'b0;
    src0 = 16'h1234; src1 = 16'h0000; src2 = 16'h0000; src3 = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_anode", 16'(a_anode), 16'h000F);
    chk("rst_a_digit", 16'(a_digit), 16'h0000);
    chk("rst_a_blank", 16'(a_blank), 16'h0001);
    chk("rst_a_fd",    16'(a_fd),    16'h0000);
    chk("rst_b_anode", 16'(b_anode), 16'h000F);
    chk("rst_b_blank", 16'(b_blank), 16'h0001);
    rst_n = 1'b1;

    // No-blank instance: from a FrameDone, 8-cycle frames with each anode lit for 2 cycles
    n = 0;
    while (!b_fd && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b_fd_seen", 16'(b_fd), 16'h0001);
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 4; k++)
        for (int c = 0; c < 2; c++) begin
          @(posedge clk); #1;
          chk("b_anode", 16'(b_anode), 16'(4'(~(4'b0001 << k))));
          chk("b_blank", 16'(b_blank), 16'h0000);
          chk("b_digit", 16'(b_digit), 16'(4'(16'h1234 >> (12 - 4 * k))));
          chk("b_fd",    16'(b_fd),    ((k == 3) && (c == 1)) ? 16'h0001 : 16'h0000);
        end

    // Restart both instances for the BLANK_CYC=1 scoreboard run
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    push_frame(16'h1234, 1'b0, -1, 0);
    run("f1", 7);
    sel = 2'd2; src2 = 16'hABCD;                  // mid-frame select change
    push_frame(16'hABCD, 1'b0, -1, 0);
    run("f1", 13);

    run("f2", 3);
    sel = 2'd0; src0 = 16'h0005; lzb = 1'b1;
    push_frame(16'h0005, 1'b1, -1, 0);
    run("f2", 17);

    run("f3", 3);
    src0 = 16'h0000;
    push_frame(16'h0000, 1'b1, -1, 0);
    run("f3", 17);

    run("f4", 3);
    src0 = 16'h9A0F; lzb = 1'b0;
    push_frame(16'h9A0F, 1'b0, 11, 7);
    run("f4", 17);

    run("f5", 3);
    push_frame(16'h9A0F, 1'b0, -1, 0);
    run("f5", 8);
    en = 1'b0;                                    // freeze inside idx2 SHOW
    run("f5", 7);
    en = 1'b1;
    run("f5", 9);

    run("f6", 5);
    sel = 2'd1; src1 = 16'h0C00; lzb = 1'b1;
    run("f6", 7);
    rst_n = 1'b0;                                 // reset during idx2 SHOW
    #1;
    chk("mrst_anode", 16'(a_anode), 16'h000F);
    chk("mrst_blank", 16'(a_blank), 16'h0001);
    chk("mrst_digit", 16'(a_digit), 16'h0000);
    chk("mrst_fd",    16'(a_fd),    16'h0000);
    sb_q.delete();
    @(posedge clk); #1;
    chk("mrst_hold_anode", 16'(a_anode), 16'h000F);
    chk("mrst_hold_fd",    16'(a_fd),    16'h0000);
    rst_n = 1'b1;
    push_frame(16'h0C00, 1'b1, -1, 0);
    push_frame(16'h0C00, 1'b1, -1, 0);
    run("f7", 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
